multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL provide the parameter NUM_STATES, default 11, giving the number of FSM state encodings.
REQ-002 SHALL provide the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL provide the port reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-004 SHALL provide the inputs Cond[3:0], Op[1:0], Funct[5:0] and Rd[3:0], each taken from the held instruction register bits 31:28, 27:26, 25:20 and 15:12.
REQ-005 SHALL provide the input ALUFlags[3:0], the ALU result flags {N,Z,C,V}.
REQ-006 SHALL provide the outputs PCWrite, RegWrite, MemWrite and IRWrite, 1 bit each, all already condition-gated.
REQ-007 SHALL provide the outputs AdrSrc (1 bit), ResultSrc[1:0], ALUSrcA (1 bit), ALUSrcB[1:0], ImmSrc[1:0], RegSrc[1:0] and ALUControl[1:0].

Function
REQ-008 SHALL use these states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN.
REQ-009 SHALL make these transitions:
- FETCH goes to DECODE.
- DECODE goes to MEMADR for Op=01, to EXECUTEI for Op=00 with Funct[5]=1, to EXECUTER for Op=00 with Funct[5]=0, to BRANCH for Op=10, and to UNKNOWN for Op=11.
- MEMADR goes to MEMREAD if Funct[0]=1, else to MEMWRITE.
- MEMREAD goes to MEMWB.
- EXECUTER and EXECUTEI go to ALUWB.
- MEMWB, MEMWRITE, ALUWB, BRANCH and UNKNOWN go to FETCH.
REQ-010 SHALL drive these Moore outputs per state; any field not listed is 0:
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcA=0, ALUSrcB=01.
- MEMREAD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWRITE: AdrSrc=1, MemW=1.
- EXECUTER: ALUSrcB=00, ALUOp=1.
- EXECUTEI: ALUSrcB=01, ALUOp=1.
- ALUWB: ResultSrc=00, RegW=1.
- BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
REQ-011 SHALL set ALUControl=00 when ALUOp=0; when ALUOp=1 it SHALL decode Funct[4:1] as 0100->00 ADD, 0010->01 SUB, 0000->10 AND, 1100->11 ORR, and any other value->00.
REQ-012 SHALL derive ImmSrc from Op: 00->00, 01->01, 10->10. RegSrc[0] SHALL be 1 only for Op=10; RegSrc[1] SHALL be 1 only for Op=01 with Funct[0]=0.
REQ-013 SHALL hold a 4-bit Flags register {N,Z,C,V} and compute CondEx combinationally from Cond and Flags using the ARM table EQ..LE, with AL (1110)=1 and 1111=0.
REQ-014 SHALL register CondEx into CondExR at the end of DECODE; all gating in later states SHALL use CondExR.
REQ-015 SHALL compute the gated outputs as:
- PCS = ((Rd==1111) & RegW) | Branch.
- PCWrite = NextPC | (PCS & CondExR).
- RegWrite = RegW & CondExR & ~(Rd==1111).
- MemWrite = MemW & CondExR.
REQ-016 SHALL, in EXECUTER or EXECUTEI when Funct[0]=1 and CondExR=1, load Flags[3:2] from ALUFlags[3:2], and also Flags[1:0] from ALUFlags[1:0] when ALUControl is 00 or 01; the new values SHALL be visible from the next cycle.
REQ-017 SHALL give a failed condition no architectural side effect other than PC+4: the state sequence is unchanged, only the writes are suppressed.
REQ-018 SHALL give the latencies LDR=5, STR=4, data-processing=4, B=3 and Op=11 =3 cycles, with no writes in UNKNOWN.

Reset
REQ-019 SHALL, while reset=0 at a clock edge, set state=FETCH, Flags=0000 and CondExR=0.
REQ-020 SHALL abandon any instruction in progress when reset is asserted mid-instruction, and SHALL assert no MemWrite, RegWrite or PCWrite in the cycle after the reset edge except the FETCH-state PCWrite/IRWrite.
REQ-021 SHALL make all outputs decode to the FETCH values during and immediately after reset.

Structure
REQ-022 SHALL place in a shared package the state enumeration, the Op codes (DP=00, MEM=01, BR=10), the ALUControl codes, the Cond codes and the ResultSrc/ALUSrcB encodings.
REQ-023 SHALL implement the Flags register, CondEx table, CondExR and write gating in one sub-module, cond_unit; the FSM and decode logic SHALL stay in multicycle_ctrl.

Verification
REQ-024 SHALL cover ADD with S=1 and Cond=1110, ALUFlags=0100: states FETCH, DECODE, EXECUTER, ALUWB; RegWrite=1 in ALUWB; Flags=0100 afterwards.
REQ-025 SHALL cover LDR (Op=01, Funct[0]=1): 5 states ending in MEMWB with ResultSrc=01 and RegWrite=1; with Rd=1111, RegWrite=0 and PCWrite=1 in MEMWB.
REQ-026 SHALL cover STR with Cond=0000 and Flags.Z=0: MEMWRITE is reached with MemWrite=0; with Z=1, MemWrite=1.
REQ-027 SHALL cover B with Cond=0001 (NE) and Z=0: PCWrite=1 in BRANCH; with Z=1, PCWrite=0 in BRANCH; in both cases the next state is FETCH.
REQ-028 SHALL cover reset=0 applied in MEMREAD: the next state is FETCH, Flags=0000, and no MemWrite or RegWrite pulse occurs.
REQ-029 SHALL cover Op=11: FETCH, DECODE, UNKNOWN, FETCH with all write strobes 0 beyond FETCH.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_pkg
// Brief    : Shared encodings and condition evaluation for the multicycle controller.
// Revision : 1.0
// ============================================================================
package multicycle_ctrl_pkg;

    localparam int c_STATE_W = 4;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_S_FETCH    = 4'd0;
    localparam state_t c_S_DECODE   = 4'd1;
    localparam state_t c_S_MEMADR   = 4'd2;
    localparam state_t c_S_MEMREAD  = 4'd3;
    localparam state_t c_S_MEMWB    = 4'd4;
    localparam state_t c_S_MEMWRITE = 4'd5;
    localparam state_t c_S_EXECUTER = 4'd6;
    localparam state_t c_S_EXECUTEI = 4'd7;
    localparam state_t c_S_ALUWB    = 4'd8;
    localparam state_t c_S_BRANCH   = 4'd9;
    localparam state_t c_S_UNKNOWN  = 4'd10;

    localparam logic [1:0] c_OP_DP  = 2'b00;
    localparam logic [1:0] c_OP_MEM = 2'b01;
    localparam logic [1:0] c_OP_BR  = 2'b10;

    localparam logic [1:0] c_ALU_ADD = 2'b00;
    localparam logic [1:0] c_ALU_SUB = 2'b01;
    localparam logic [1:0] c_ALU_AND = 2'b10;
    localparam logic [1:0] c_ALU_ORR = 2'b11;

    localparam logic [1:0] c_RES_ALUOUT = 2'b00;
    localparam logic [1:0] c_RES_DATA   = 2'b01;
    localparam logic [1:0] c_RES_ALU    = 2'b10;

    localparam logic [1:0] c_SRCB_REG  = 2'b00;
    localparam logic [1:0] c_SRCB_IMM  = 2'b01;
    localparam logic [1:0] c_SRCB_FOUR = 2'b10;

    localparam logic [3:0] c_COND_EQ = 4'b0000;
    localparam logic [3:0] c_COND_NE = 4'b0001;
    localparam logic [3:0] c_COND_CS = 4'b0010;
    localparam logic [3:0] c_COND_CC = 4'b0011;
    localparam logic [3:0] c_COND_MI = 4'b0100;
    localparam logic [3:0] c_COND_PL = 4'b0101;
    localparam logic [3:0] c_COND_VS = 4'b0110;
    localparam logic [3:0] c_COND_VC = 4'b0111;
    localparam logic [3:0] c_COND_HI = 4'b1000;
    localparam logic [3:0] c_COND_LS = 4'b1001;
    localparam logic [3:0] c_COND_GE = 4'b1010;
    localparam logic [3:0] c_COND_LT = 4'b1011;
    localparam logic [3:0] c_COND_GT = 4'b1100;
    localparam logic [3:0] c_COND_LE = 4'b1101;
    localparam logic [3:0] c_COND_AL = 4'b1110;

    // flags are packed {N,Z,C,V}; the reserved 1111 code never executes
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        {n, z, c, v} = flags;
        case (cond)
            c_COND_EQ: cond_eval = z;
            c_COND_NE: cond_eval = ~z;
            c_COND_CS: cond_eval = c;
            c_COND_CC: cond_eval = ~c;
            c_COND_MI: cond_eval = n;
            c_COND_PL: cond_eval = ~n;
            c_COND_VS: cond_eval = v;
            c_COND_VC: cond_eval = ~v;
            c_COND_HI: cond_eval = c & ~z;
            c_COND_LS: cond_eval = ~c | z;
            c_COND_GE: cond_eval = (n == v);
            c_COND_LT: cond_eval = (n != v);
            c_COND_GT: cond_eval = ~z & (n == v);
            c_COND_LE: cond_eval = z | (n != v);
            c_COND_AL: cond_eval = 1'b1;
            default:   cond_eval = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_if
// Brief    : Instruction/flag inputs and control outputs between datapath and controller.
// Revision : 1.0
// ============================================================================
interface multicycle_ctrl_if;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ResultSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [1:0] ALUControl;

    modport master (
        output Cond, Op, Funct, Rd, ALUFlags,
        input  PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl
    );

    modport slave (
        input  Cond, Op, Funct, Rd, ALUFlags,
        output PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl_cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : cond_unit
// Brief    : Flags register, condition check latched at DECODE, and write-strobe gating.
// Revision : 1.0
// ============================================================================
module cond_unit
    import multicycle_ctrl_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic [3:0] i_cond,
    input  wire logic [3:0] i_alu_flags,
    input  wire logic       i_latch_cond,
    input  wire logic       i_flag_wr_nz,
    input  wire logic       i_flag_wr_cv,
    input  wire logic       i_regw,
    input  wire logic       i_memw,
    input  wire logic       i_nextpc,
    input  wire logic       i_branch,
    input  wire logic       i_rd_is_pc,
    output logic            o_pcwrite,
    output logic            o_regwrite,
    output logic            o_memwrite
);

    logic [3:0] r_flags;
    logic       r_condexr;
    logic       w_condex;
    logic       w_pcs;

    assign w_condex = cond_eval(i_cond, r_flags);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_flags   <= 4'b0000;
            r_condexr <= 1'b0;
        end else begin
            if (i_latch_cond)
                r_condexr <= w_condex;
            if (i_flag_wr_nz && r_condexr)
                r_flags[3:2] <= i_alu_flags[3:2];
            if (i_flag_wr_cv && r_condexr)
                r_flags[1:0] <= i_alu_flags[1:0];
        end
    end

    // A write to R15 is a PC write, never a register-file write
    assign w_pcs      = (i_rd_is_pc & i_regw) | i_branch;
    assign o_pcwrite  = i_nextpc | (w_pcs & r_condexr);
    assign o_regwrite = i_regw & r_condexr & ~i_rd_is_pc;
    assign o_memwrite = i_memw & r_condexr;

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Multicycle ARM-subset controller: main FSM, Moore decode and ALU/imm decode.
// Revision : 1.0
// ============================================================================
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int NUM_STATES = 11
) (
    input wire logic         clk,
    input wire logic         reset,
    multicycle_ctrl_if.slave bus
);

    localparam int c_SW = $clog2(NUM_STATES);

    logic [c_SW-1:0] r_state;
    logic [c_SW-1:0] w_state;
    logic [c_SW-1:0] w_next;
    logic            w_nextpc, w_branch, w_regw, w_memw, w_aluop;
    logic            w_exec, w_flag_nz;
    logic [1:0]      w_alucontrol;

    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= c_S_FETCH;
        else
            r_state <= w_next;
    end

    // Outputs decode as FETCH while reset is held, not only after the edge
    assign w_state = reset ? r_state : c_S_FETCH;

    always_comb begin
        w_next = c_S_FETCH;
        case (w_state)
            c_S_FETCH:  w_next = c_S_DECODE;
            c_S_DECODE: begin
                case (bus.Op)
                    c_OP_MEM: w_next = c_S_MEMADR;
                    c_OP_DP:  w_next = bus.Funct[5] ? c_S_EXECUTEI : c_S_EXECUTER;
                    c_OP_BR:  w_next = c_S_BRANCH;
                    default:  w_next = c_S_UNKNOWN;
                endcase
            end
            c_S_MEMADR:   w_next = bus.Funct[0] ? c_S_MEMREAD : c_S_MEMWRITE;
            c_S_MEMREAD:  w_next = c_S_MEMWB;
            c_S_EXECUTER: w_next = c_S_ALUWB;
            c_S_EXECUTEI: w_next = c_S_ALUWB;
            default:      w_next = c_S_FETCH;
        endcase
    end

    always_comb begin
        bus.AdrSrc    = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = c_SRCB_REG;
        bus.ResultSrc = c_RES_ALUOUT;
        bus.IRWrite   = 1'b0;
        w_nextpc      = 1'b0;
        w_branch      = 1'b0;
        w_regw        = 1'b0;
        w_memw        = 1'b0;
        w_aluop       = 1'b0;
        case (w_state)
            c_S_FETCH: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = c_SRCB_FOUR;
                bus.ResultSrc = c_RES_ALU;
                bus.IRWrite   = 1'b1;
                w_nextpc      = 1'b1;
            end
            c_S_DECODE: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = c_SRCB_FOUR;
                bus.ResultSrc = c_RES_ALU;
            end
            c_S_MEMADR:   bus.ALUSrcB = c_SRCB_IMM;
            c_S_MEMREAD:  bus.AdrSrc  = 1'b1;
            c_S_MEMWB: begin
                bus.ResultSrc = c_RES_DATA;
                w_regw        = 1'b1;
            end
            c_S_MEMWRITE: begin
                bus.AdrSrc = 1'b1;
                w_memw     = 1'b1;
            end
            c_S_EXECUTER: w_aluop = 1'b1;
            c_S_EXECUTEI: begin
                bus.ALUSrcB = c_SRCB_IMM;
                w_aluop     = 1'b1;
            end
            c_S_ALUWB:    w_regw = 1'b1;
            c_S_BRANCH: begin
                bus.ALUSrcB   = c_SRCB_IMM;
                bus.ResultSrc = c_RES_ALU;
                w_branch      = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_alucontrol = c_ALU_ADD;
        if (w_aluop) begin
            case (bus.Funct[4:1])
                4'b0100: w_alucontrol = c_ALU_ADD;
                4'b0010: w_alucontrol = c_ALU_SUB;
                4'b0000: w_alucontrol = c_ALU_AND;
                4'b1100: w_alucontrol = c_ALU_ORR;
                default: w_alucontrol = c_ALU_ADD;
            endcase
        end
    end

    assign bus.ALUControl = w_alucontrol;
    assign bus.ImmSrc     = (bus.Op == 2'b11) ? 2'b00 : bus.Op;
    assign bus.RegSrc     = {(bus.Op == c_OP_MEM) & ~bus.Funct[0], bus.Op == c_OP_BR};

    // Logical ops leave C and V untouched
    assign w_exec    = (w_state == c_S_EXECUTER) || (w_state == c_S_EXECUTEI);
    assign w_flag_nz = w_exec & bus.Funct[0];

    cond_unit u_cond (
        .clk          (clk),
        .reset        (reset),
        .i_cond       (bus.Cond),
        .i_alu_flags  (bus.ALUFlags),
        .i_latch_cond (w_state == c_S_DECODE),
        .i_flag_wr_nz (w_flag_nz),
        .i_flag_wr_cv (w_flag_nz & ~w_alucontrol[1]),
        .i_regw       (w_regw),
        .i_memw       (w_memw),
        .i_nextpc     (w_nextpc),
        .i_branch     (w_branch),
        .i_rd_is_pc   (bus.Rd == 4'b1111),
        .o_pcwrite    (bus.PCWrite),
        .o_regwrite   (bus.RegWrite),
        .o_memwrite   (bus.MemWrite)
    );

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Instruction-level vector table with per-cycle scoreboard, plus reset corner case.
// Revision : 1.0
// ============================================================================
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    typedef struct {
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic [3:0] aluf;
        int         ncyc;
        logic       pcw;
        logic       regw;
        logic       memw;
        logic [1:0] rsrc;
        logic [1:0] aluc;
        logic [3:0] flags;
    } vec_t;

    typedef struct {
        logic [3:0] strobes;
        logic       last;
        logic [1:0] rsrc;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    vec_t vt[15];
    exp_t sbq[$];

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.NUM_STATES(11)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [3:0] strobes();
        return {bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite};
    endfunction

    // Entered at the falling edge of a FETCH cycle; leaves at the next FETCH
    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        logic [1:0] imm;
        logic [1:0] rsrc_exp;
        bus.Cond     = v.cond;
        bus.Op       = v.op;
        bus.Funct    = v.funct;
        bus.Rd       = v.rd;
        bus.ALUFlags = v.aluf;
        for (int c = 0; c < v.ncyc; c++) begin
            e.last    = (c == v.ncyc - 1);
            e.rsrc    = v.rsrc;
            e.strobes = (c == 0) ? 4'b1100 : (e.last ? {2'b00, v.regw, v.memw} | {1'b0, v.pcw, 2'b00} : 4'b0000);
            sbq.push_back(e);
        end
        for (int c = 0; c < v.ncyc; c++) begin
            #1;
            e = sbq.pop_front();
            check($sformatf("v%0d cyc%0d strobes", idx, c), {4'h0, strobes()}, {4'h0, e.strobes});
            if (e.last)
                check($sformatf("v%0d ResultSrc", idx), {6'h0, bus.ResultSrc}, {6'h0, e.rsrc});
            if (c == 1) begin
                imm      = (v.op == 2'b11) ? 2'b00 : v.op;
                rsrc_exp = {(v.op == 2'b01) && !v.funct[0], v.op == 2'b10};
                check($sformatf("v%0d ImmSrc/RegSrc", idx), {4'h0, bus.ImmSrc, bus.RegSrc}, {4'h0, imm, rsrc_exp});
            end
            if (c == 2 && v.op == 2'b00)
                check($sformatf("v%0d ALUControl", idx), {6'h0, bus.ALUControl}, {6'h0, v.aluc});
            @(negedge clk);
        end
        #1;
        check($sformatf("v%0d flags", idx), {4'h0, dut.u_cond.r_flags}, {4'h0, v.flags});
        check($sformatf("v%0d next FETCH", idx), {4'h0, dut.r_state}, {4'h0, c_S_FETCH});
    endtask

    initial begin
        clk      = 1'b0;
        reset    = 1'b0;
        n_checks = 0;
        n_pass   = 0;
        bus.Cond = 4'h0; bus.Op = 2'b00; bus.Funct = 6'h0; bus.Rd = 4'h0; bus.ALUFlags = 4'h0;

        //         cond     op     funct      rd       aluf   n  pcw  regw memw rsrc   aluc   flags
        vt[0]  = '{4'b1110, 2'b00, 6'b001001, 4'b0001, 4'b0100, 4, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 4'b0100}; // ADDS
        vt[1]  = '{4'b0001, 2'b10, 6'b000000, 4'b0000, 4'b0000, 3, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 4'b0100}; // BNE, Z=1
        vt[2]  = '{4'b0000, 2'b01, 6'b000000, 4'b0010, 4'b0000, 4, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 4'b0100}; // STREQ, Z=1
        vt[3]  = '{4'b1110, 2'b00, 6'b100101, 4'b0011, 4'b0011, 4, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 4'b0011}; // SUBS imm
        vt[4]  = '{4'b0000, 2'b01, 6'b000000, 4'b0010, 4'b0000, 4, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0011}; // STREQ, Z=0
        vt[5]  = '{4'b0001, 2'b10, 6'b000000, 4'b0000, 4'b0000, 3, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 4'b0011}; // BNE, Z=0
        vt[6]  = '{4'b1110, 2'b01, 6'b000001, 4'b0010, 4'b0000, 5, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 4'b0011}; // LDR
        vt[7]  = '{4'b1110, 2'b01, 6'b000001, 4'b1111, 4'b0000, 5, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 4'b0011}; // LDR PC
        vt[8]  = '{4'b1110, 2'b00, 6'b011001, 4'b0100, 4'b1000, 4, 1'b0, 1'b1, 1'b0, 2'b00, 2'b11, 4'b1011}; // ORRS keeps C,V
        vt[9]  = '{4'b1110, 2'b11, 6'b000000, 4'b0001, 4'b0000, 3, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b1011}; // Op=11
        vt[10] = '{4'b0000, 2'b00, 6'b000001, 4'b0101, 4'b0100, 4, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 4'b1011}; // ANDSEQ fails
        vt[11] = '{4'b1110, 2'b00, 6'b001000, 4'b1111, 4'b0000, 4, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b1011}; // ADD PC
        vt[12] = '{4'b1010, 2'b00, 6'b001000, 4'b0011, 4'b0000, 4, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 4'b1011}; // ADDGE passes
        vt[13] = '{4'b1011, 2'b10, 6'b000000, 4'b0000, 4'b0000, 3, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 4'b1011}; // BLT fails
        vt[14] = '{4'b1110, 2'b00, 6'b000011, 4'b0110, 4'b1111, 4, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 4'b1111}; // EORS -> ADD code

        repeat (2) @(negedge clk);
        #1;
        check("reset strobes", {4'h0, strobes()}, 8'h0C);
        check("reset datapath selects", {2'b00, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc}, 8'b00_0_1_10_10);
        check("reset flags", {4'h0, dut.u_cond.r_flags}, 8'h00);
        check("reset state", {4'h0, dut.r_state}, {4'h0, c_S_FETCH});
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 15; i++)
            run_vec(i, vt[i]);

        // Reset dropped while an LDR sits in MEMREAD
        bus.Cond = 4'b1110; bus.Op = 2'b01; bus.Funct = 6'b000001; bus.Rd = 4'b0010;
        repeat (3) @(negedge clk);
        #1;
        check("pre-reset MEMREAD", {4'h0, dut.r_state}, {4'h0, c_S_MEMREAD});
        reset = 1'b0;
        #1;
        check("in-reset strobes", {4'h0, strobes()}, 8'h0C);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post-reset state", {4'h0, dut.r_state}, {4'h0, c_S_FETCH});
        check("post-reset flags", {4'h0, dut.u_cond.r_flags}, 8'h00);
        check("post-reset condexr", {7'h0, dut.u_cond.r_condexr}, 8'h00);
        check("post-reset strobes", {4'h0, strobes()}, 8'h0C);
        @(negedge clk);
        #1;
        check("post-reset DECODE", {4'h0, dut.r_state}, {4'h0, c_S_DECODE});
        check("post-reset DECODE strobes", {4'h0, strobes()}, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
